// File: rtl/decoder_2to4_seq_pkg.sv
// -----------------------------------------------------------------------------
// decoder_2to4_seq_pkg
// Shared definitions for the sequenced 2-to-4 decoder and its neighbours:
//   - state_e    : FSM state encoding (IDLE / DRIVE / GAP)
//   - LINE0..3   : one-hot line constants (also used by encoder benches)
//   - ctr_width(): width of the shared hold/gap down-counter
// -----------------------------------------------------------------------------
package decoder_2to4_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    localparam logic [3:0] LINE0 = 4'b0001;
    localparam logic [3:0] LINE1 = 4'b0010;
    localparam logic [3:0] LINE2 = 4'b0100;
    localparam logic [3:0] LINE3 = 4'b1000;

    // One counter serves both the hold and the gap phase, so it must be able
    // to hold the larger of the two reload values; never narrower than 1 bit.
    function automatic int ctr_width(input int hold_cycles, input int gap_cycles);
        int max_cycles;
        int w;
        max_cycles = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
        w          = $clog2(max_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decoder_2to4_seq_if.sv
// -----------------------------------------------------------------------------
// decoder_2to4_seq_if
// Valid/ready code channel from an encoder (master) to the decoder (slave).
//   code_i     : 2-bit encoded line index   (master -> slave)
//   code_v_i   : code valid                 (master -> slave)
//   code_rdy_o : decoder can accept a code  (slave  -> master)
// -----------------------------------------------------------------------------
interface decoder_2to4_seq_if;

    logic [1:0] code_i;
    logic       code_v_i;
    logic       code_rdy_o;

    modport master (
        output code_i,
        output code_v_i,
        input  code_rdy_o
    );

    modport slave (
        input  code_i,
        input  code_v_i,
        output code_rdy_o
    );

endinterface

// File: rtl/decoder_2to4_seq_df.sv
// -----------------------------------------------------------------------------
// decoder_2to4_df
// Pure combinational 2-to-4 decode.
//   code : 2-bit line index (0 -> line0 ... 3 -> line3)
//   line : one-hot line select
// -----------------------------------------------------------------------------
module decoder_2to4_df
    import decoder_2to4_seq_pkg::*;
(
    input  logic [1:0] code,
    output logic [3:0] line
);

    always_comb begin
        unique case (code)
            2'd0:    line = LINE0;
            2'd1:    line = LINE1;
            2'd2:    line = LINE2;
            default: line = LINE3;
        endcase
    end

endmodule

// File: rtl/decoder_2to4_seq.sv
// -----------------------------------------------------------------------------
// decoder_2to4_seq
// Sequenced 2-to-4 decoder. Accepts one encoded code per valid/ready
// handshake, drives the matching one-hot line for HOLD_CYCLES cycles, then
// outputs all-zero for GAP_CYCLES cycles before accepting again.
//
// Ports:
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   hs       : code channel (slave side): code_i, code_v_i, code_rdy_o
//   abort_i  : synchronous abort of the current hold/gap
//   d_o      : registered one-hot output (zero outside the hold)
//   busy_o   : high while in DRIVE or GAP
//   done_o   : one-cycle pulse when a hold completes without abort
//   cnt_o    : wrapping count of completed decodes
// -----------------------------------------------------------------------------
module decoder_2to4_seq
    import decoder_2to4_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    decoder_2to4_seq_if.slave    hs,
    input  logic                 abort_i,
    output logic [3:0]           d_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [CNT_W-1:0]     cnt_o
);

    localparam int CTR_W = ctr_width(HOLD_CYCLES, GAP_CYCLES);

    // Counter reload values: the counter runs N-1 .. 0, so a phase lasts N cycles.
    localparam logic [CTR_W-1:0] HOLD_LOAD = CTR_W'(HOLD_CYCLES - 1);
    localparam logic [CTR_W-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CTR_W'(GAP_CYCLES - 1) : '0;

    state_e           state;
    state_e           state_n;
    logic [CTR_W-1:0] ctr;
    logic             ctr_zero;
    logic             accept;
    logic [3:0]       line_dec;

    decoder_2to4_df u_df (
        .code (hs.code_i),
        .line (line_dec)
    );

    assign ctr_zero = (ctr == '0);
    assign accept   = hs.code_v_i & hs.code_rdy_o;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches on paths that do not change state.
    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (abort_i) begin
                    state_n = ST_IDLE;
                end else if (ctr_zero) begin
                    state_n = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
                end
            end
            ST_GAP: begin
                if (abort_i || ctr_zero) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Combinational outputs
    // ---------------------------------------------------------------------
    // Abort blocks acceptance in the same cycle, so abort beats a valid code.
    always_comb begin
        hs.code_rdy_o = (state == ST_IDLE) && !abort_i;
        busy_o        = (state != ST_IDLE);
    end

    // ---------------------------------------------------------------------
    // Datapath: line register, hold/gap counter, done pulse, decode count
    // ---------------------------------------------------------------------
    // NOTE: all datapath registers are plain flops (no memories), so every
    // one of them takes its reset value asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_o    <= '0;
            ctr    <= '0;
            done_o <= 1'b0;
            cnt_o  <= '0;
        end else begin
            done_o <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        // The line is captured here; code_i is ignored until IDLE.
                        d_o <= line_dec;
                        ctr <= HOLD_LOAD;
                    end else begin
                        d_o <= '0;
                    end
                end
                ST_DRIVE: begin
                    if (abort_i) begin
                        d_o <= '0;
                        ctr <= '0;
                    end else if (!ctr_zero) begin
                        ctr <= ctr - CTR_W'(1);
                    end else begin
                        d_o    <= '0;
                        done_o <= 1'b1;
                        cnt_o  <= cnt_o + CNT_W'(1);
                        ctr    <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    d_o <= '0;
                    if (abort_i) begin
                        ctr <= '0;
                    end else if (!ctr_zero) begin
                        ctr <= ctr - CTR_W'(1);
                    end
                end
                default: begin
                    d_o <= '0;
                    ctr <= '0;
                end
            endcase
        end
    end

endmodule
